// File: rtl/div_sqrt_arb_mvp_if.sv
// Request/response/unit bus for the two-requester div/sqrt arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface div_sqrt_arb_mvp_if #(
    parameter int unsigned TAG_W = 4
);
    logic [1:0]         Req_valid_SI;
    logic [1:0]         Req_op_SI;
    logic [2*TAG_W-1:0] Req_tag_DI;
    logic [1:0]         Req_ready_SO;
    logic [1:0]         Kill_SI;
    logic               Grant_id_SO;
    logic               Unit_div_start_SO;
    logic               Unit_sqrt_start_SO;
    logic               Unit_kill_SO;
    logic               Unit_ready_SI;
    logic               Unit_done_SI;
    logic               Capture_SO;
    logic               Rsp_valid_SO;
    logic               Rsp_ready_SI;
    logic               Rsp_id_SO;
    logic [TAG_W-1:0]   Rsp_tag_DO;
    logic               Error_SO;

    modport slave (
        input  Req_valid_SI, Req_op_SI, Req_tag_DI, Kill_SI,
        input  Unit_ready_SI, Unit_done_SI, Rsp_ready_SI,
        output Req_ready_SO, Grant_id_SO, Unit_div_start_SO, Unit_sqrt_start_SO,
        output Unit_kill_SO, Capture_SO, Rsp_valid_SO, Rsp_id_SO, Rsp_tag_DO, Error_SO
    );

    modport master (
        output Req_valid_SI, Req_op_SI, Req_tag_DI, Kill_SI,
        output Unit_ready_SI, Unit_done_SI, Rsp_ready_SI,
        input  Req_ready_SO, Grant_id_SO, Unit_div_start_SO, Unit_sqrt_start_SO,
        input  Unit_kill_SO, Capture_SO, Rsp_valid_SO, Rsp_id_SO, Rsp_tag_DO, Error_SO
    );
endinterface

// File: rtl/div_sqrt_arb_mvp.sv
// Round-robin arbiter sharing one div/sqrt unit between two requesters.
// Optional BUSY watchdog enabled by defining DIV_SQRT_ARB_TIMEOUT_EN.
module div_sqrt_arb_mvp #(
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input logic               Clk_CI,
    input logic               Rst_RBI,
    div_sqrt_arb_mvp_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, BUSY, RESP} state_t;

    state_t           state, state_nxt;
    logic             ptr;
    logic             grant;
    logic             op_q;
    logic [TAG_W-1:0] tag_q;
    logic             gnt;
    logic             hs;
    logic             owner_kill;
    logic             timeout;
    logic             div_start, sqrt_start, unit_kill, capture, err;

    // Round-robin pick: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        gnt = ptr;
        if (bus.Req_valid_SI == 2'b01) gnt = 1'b0;
        else if (bus.Req_valid_SI == 2'b10) gnt = 1'b1;
    end

    assign hs         = (state == IDLE) && bus.Unit_ready_SI && bus.Req_valid_SI[gnt];
    assign owner_kill = bus.Kill_SI[grant];

`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] busy_cnt;

    // Count cycles spent in BUSY; cleared whenever the FSM is elsewhere.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI || state != BUSY) busy_cnt <= '0;
        else                           busy_cnt <= busy_cnt + CNT_W'(1);
    end

    assign timeout = (state == BUSY) && (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register plus the request context latched at the handshake.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            state <= IDLE;
            ptr   <= 1'b0;
            grant <= 1'b0;
            op_q  <= 1'b0;
            tag_q <= '0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                ptr   <= ~gnt;
                grant <= gnt;
                op_q  <= bus.Req_op_SI[gnt];
                tag_q <= gnt ? bus.Req_tag_DI[2*TAG_W-1:TAG_W] : bus.Req_tag_DI[TAG_W-1:0];
            end
        end
    end

    // Next state and unit-side pulses; an owner kill outranks done and timeout.
    always_comb begin
        state_nxt  = state;
        div_start  = 1'b0;
        sqrt_start = 1'b0;
        unit_kill  = 1'b0;
        capture    = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: if (hs) state_nxt = START;
            START: begin
                if (owner_kill) begin
                    unit_kill = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    div_start  = ~op_q;
                    sqrt_start = op_q;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                capture = bus.Unit_done_SI;
                if (owner_kill) begin
                    unit_kill = 1'b1;
                    state_nxt = IDLE;
                end else if (bus.Unit_done_SI) begin
                    state_nxt = RESP;
                end else if (timeout) begin
                    unit_kill = 1'b1;
                    err       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RESP: if (owner_kill || bus.Rsp_ready_SI) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs are masked while reset is asserted so a reset
    // taken mid-operation never produces a stray kill or start pulse.
    assign bus.Req_ready_SO       = (hs && Rst_RBI) ? (2'b01 << gnt) : 2'b00;
    assign bus.Unit_div_start_SO  = div_start & Rst_RBI;
    assign bus.Unit_sqrt_start_SO = sqrt_start & Rst_RBI;
    assign bus.Unit_kill_SO       = unit_kill & Rst_RBI;
    assign bus.Capture_SO         = capture & Rst_RBI;
    assign bus.Error_SO           = err & Rst_RBI;
    assign bus.Grant_id_SO        = grant;
    assign bus.Rsp_valid_SO       = (state == RESP);
    assign bus.Rsp_id_SO          = grant;
    assign bus.Rsp_tag_DO         = tag_q;

endmodule

// File: tb/tb_div_sqrt_arb_mvp.sv
// Self-checking bench for div_sqrt_arb_mvp: directed scenarios plus random
// transactions checked against a round-robin/transaction-level model.
module tb_div_sqrt_arb_mvp;

    localparam int unsigned TAG_W       = 4;
    localparam int unsigned TIMEOUT_CYC = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   m_ptr = 1'b0;

    always #5 clk = ~clk;

    div_sqrt_arb_mvp_if #(.TAG_W(TAG_W)) bus ();

    div_sqrt_arb_mvp #(.TAG_W(TAG_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .Clk_CI  (clk),
        .Rst_RBI (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: lone requester wins, otherwise the pointer holder wins.
    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return int'(m_ptr);
    endfunction

    // Present a request, check the ready mask, take the handshake edge.
    // Leaves the bench in the START cycle.
    task automatic accept(input logic [1:0] valid, input logic [1:0] op,
                          input logic [2*TAG_W-1:0] tags, output int g);
        g = exp_grant(valid);
        bus.Req_valid_SI = valid;
        bus.Req_op_SI    = op;
        bus.Req_tag_DI   = tags;
        #1;
        chk("req_ready", 32'(bus.Req_ready_SO), 32'(1) << g);
        tick();
        m_ptr = (g == 0);
        chk("grant_id", 32'(bus.Grant_id_SO), 32'(g));
    endtask

    task automatic do_txn(input logic [1:0] valid, input logic [1:0] op,
                          input logic [2*TAG_W-1:0] tags, input int lat, input int bp);
        int g;
        logic [TAG_W-1:0] t;
        accept(valid, op, tags, g);
        t = tags[g*TAG_W +: TAG_W];
        chk("div_start", 32'(bus.Unit_div_start_SO), 32'(!op[g]));
        chk("sqrt_start", 32'(bus.Unit_sqrt_start_SO), 32'(op[g]));
        chk("ready_start", 32'(bus.Req_ready_SO), 32'd0);
        tick();
        for (int i = 1; i < lat; i++) begin
            chk("busy_capture", 32'(bus.Capture_SO), 32'd0);
            chk("busy_rsp_valid", 32'(bus.Rsp_valid_SO), 32'd0);
            chk("busy_start", 32'(bus.Unit_div_start_SO | bus.Unit_sqrt_start_SO), 32'd0);
            chk("busy_ready", 32'(bus.Req_ready_SO), 32'd0);
            tick();
        end
        bus.Unit_done_SI = 1'b1;
        #1;
        chk("capture", 32'(bus.Capture_SO), 32'd1);
        tick();
        bus.Unit_done_SI = 1'b0;
        chk("rsp_valid", 32'(bus.Rsp_valid_SO), 32'd1);
        chk("rsp_id", 32'(bus.Rsp_id_SO), 32'(g));
        chk("rsp_tag", 32'(bus.Rsp_tag_DO), 32'(t));
        for (int i = 0; i < bp; i++) begin
            bus.Unit_done_SI = 1'($urandom_range(0, 1));
            #1;
            chk("bp_valid", 32'(bus.Rsp_valid_SO), 32'd1);
            chk("bp_id", 32'(bus.Rsp_id_SO), 32'(g));
            chk("bp_tag", 32'(bus.Rsp_tag_DO), 32'(t));
            chk("bp_ready", 32'(bus.Req_ready_SO), 32'd0);
            chk("bp_capture", 32'(bus.Capture_SO), 32'd0);
            tick();
        end
        bus.Unit_done_SI = 1'b0;
        bus.Rsp_ready_SI = 1'b1;
        #1;
        chk("rsp_hs_ready", 32'(bus.Req_ready_SO), 32'd0);
        tick();
        bus.Rsp_ready_SI = 1'b0;
        chk("rsp_drop", 32'(bus.Rsp_valid_SO), 32'd0);
        bus.Req_valid_SI = 2'b00;
    endtask

    initial begin
        int g;
        bus.Req_valid_SI  = '0;
        bus.Req_op_SI     = '0;
        bus.Req_tag_DI    = '0;
        bus.Kill_SI       = '0;
        bus.Unit_ready_SI = 1'b1;
        bus.Unit_done_SI  = 1'b0;
        bus.Rsp_ready_SI  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_rsp_valid", 32'(bus.Rsp_valid_SO), 32'd0);
        chk("rst_grant", 32'(bus.Grant_id_SO), 32'd0);
        chk("rst_tag", 32'(bus.Rsp_tag_DO), 32'd0);
        chk("rst_kill", 32'(bus.Unit_kill_SO), 32'd0);
        chk("rst_error", 32'(bus.Error_SO), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_ready", 32'(bus.Req_ready_SO), 32'd0);

        // Unit not ready blocks acceptance
        bus.Unit_ready_SI = 1'b0;
        bus.Req_valid_SI  = 2'b01;
        #1;
        chk("unit_busy_ready", 32'(bus.Req_ready_SO), 32'd0);
        bus.Unit_ready_SI = 1'b1;

        // Kill in IDLE is ignored
        bus.Kill_SI = 2'b11;
        #1;
        chk("idle_kill_ready", 32'(bus.Req_ready_SO), 32'd1);
        chk("idle_kill_out", 32'(bus.Unit_kill_SO), 32'd0);
        bus.Kill_SI = 2'b00;

        // Contention right after reset: req0 (div) first, 10-cycle backpressure,
        // then req1 (sqrt) in the first IDLE cycle after the response.
        do_txn(2'b11, 2'b10, {4'd9, 4'd3}, 3, 10);
        do_txn(2'b11, 2'b10, {4'd9, 4'd3}, 2, 0);

        // Single request: req0 div tag 5, done 20 cycles after accept
        do_txn(2'b01, 2'b00, {4'd0, 4'd5}, 19, 0);

        // Kill during START suppresses the start pulse
        accept(2'b10, 2'b11, {4'd7, 4'd1}, g);
        bus.Kill_SI = 2'b10;
        #1;
        chk("kstart_kill", 32'(bus.Unit_kill_SO), 32'd1);
        chk("kstart_starts", 32'(bus.Unit_div_start_SO | bus.Unit_sqrt_start_SO), 32'd0);
        tick();
        bus.Kill_SI = 2'b00;
        chk("kstart_kill_off", 32'(bus.Unit_kill_SO), 32'd0);
        chk("kstart_no_rsp", 32'(bus.Rsp_valid_SO), 32'd0);
        chk("kstart_idle", 32'(bus.Req_ready_SO), 32'd2);
        bus.Req_valid_SI = 2'b00;

        // Kill in BUSY coincident with done: no response, IDLE next cycle
        accept(2'b01, 2'b00, {4'd2, 4'd6}, g);
        tick();
        tick();
        bus.Kill_SI      = 2'b01;
        bus.Unit_done_SI = 1'b1;
        #1;
        chk("kbusy_kill", 32'(bus.Unit_kill_SO), 32'd1);
        tick();
        bus.Kill_SI      = 2'b00;
        bus.Unit_done_SI = 1'b0;
        chk("kbusy_kill_off", 32'(bus.Unit_kill_SO), 32'd0);
        chk("kbusy_no_rsp", 32'(bus.Rsp_valid_SO), 32'd0);
        chk("kbusy_idle", 32'(bus.Req_ready_SO), 32'd1);
        bus.Req_valid_SI = 2'b00;
        tick();
        chk("kbusy_no_rsp2", 32'(bus.Rsp_valid_SO), 32'd0);

        // Non-owner kill ignored in BUSY and RESP; owner kill drops RESP
        accept(2'b10, 2'b00, {4'd12, 4'd0}, g);
        bus.Req_valid_SI = 2'b00;
        tick();
        bus.Kill_SI = 2'b01;
        #1;
        chk("nokill_busy", 32'(bus.Unit_kill_SO), 32'd0);
        bus.Unit_done_SI = 1'b1;
        tick();
        bus.Unit_done_SI = 1'b0;
        chk("nokill_rsp", 32'(bus.Rsp_valid_SO), 32'd1);
        tick();
        chk("nokill_rsp_hold", 32'(bus.Rsp_valid_SO), 32'd1);
        chk("nokill_rsp_tag", 32'(bus.Rsp_tag_DO), 32'd12);
        bus.Kill_SI = 2'b10;
        #1;
        chk("kresp_no_unit_kill", 32'(bus.Unit_kill_SO), 32'd0);
        tick();
        bus.Kill_SI = 2'b00;
        chk("kresp_drop", 32'(bus.Rsp_valid_SO), 32'd0);

        // Randomised transactions against the model
        for (int n = 0; n < 12; n++) begin
            do_txn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                   (2*TAG_W)'($urandom()), $urandom_range(1, 5), $urandom_range(0, 3));
        end

        // Watchdog
        accept(2'b01, 2'b00, {4'd0, 4'd4}, g);
        bus.Req_valid_SI = 2'b00;
        tick();
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        for (int i = 1; i < TIMEOUT_CYC; i++) begin
            chk("wd_quiet_err", 32'(bus.Error_SO), 32'd0);
            chk("wd_quiet_kill", 32'(bus.Unit_kill_SO), 32'd0);
            tick();
        end
        chk("wd_error", 32'(bus.Error_SO), 32'd1);
        chk("wd_kill", 32'(bus.Unit_kill_SO), 32'd1);
        tick();
        chk("wd_error_off", 32'(bus.Error_SO), 32'd0);
        chk("wd_no_rsp", 32'(bus.Rsp_valid_SO), 32'd0);
        bus.Req_valid_SI = 2'b10;
        #1;
        chk("wd_idle", 32'(bus.Req_ready_SO), 32'd2);
        bus.Req_valid_SI = 2'b00;
`else
        for (int i = 0; i < 30; i++) begin
            chk("nowd_err", 32'(bus.Error_SO), 32'd0);
            chk("nowd_kill", 32'(bus.Unit_kill_SO), 32'd0);
            tick();
        end
        bus.Unit_done_SI = 1'b1;
        tick();
        bus.Unit_done_SI = 1'b0;
        chk("nowd_rsp", 32'(bus.Rsp_valid_SO), 32'd1);
        bus.Rsp_ready_SI = 1'b1;
        tick();
        bus.Rsp_ready_SI = 1'b0;
`endif

        // Reset mid-BUSY with the pointer at 1: everything clears, no kill
        accept(m_ptr ? 2'b01 : 2'b11, 2'b00, {4'd8, 4'd11}, g);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rbusy_no_kill", 32'(bus.Unit_kill_SO), 32'd0);
        tick();
        chk("rbusy_kill", 32'(bus.Unit_kill_SO), 32'd0);
        chk("rbusy_grant", 32'(bus.Grant_id_SO), 32'd0);
        chk("rbusy_rsp", 32'(bus.Rsp_valid_SO), 32'd0);
        chk("rbusy_tag", 32'(bus.Rsp_tag_DO), 32'd0);
        chk("rbusy_ready", 32'(bus.Req_ready_SO), 32'd0);
        chk("rbusy_capture", 32'(bus.Capture_SO), 32'd0);
        rst_n = 1'b1;
        bus.Req_valid_SI = 2'b11;
        #1;
        chk("rbusy_ptr0", 32'(bus.Req_ready_SO), 32'd1);
        m_ptr = 1'b0;
        do_txn(2'b11, 2'b01, {4'd14, 4'd13}, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
